// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces three raw slot sensors and
// emits mutually exclusive single-cycle coin/reject pulses for the seller FSM.
module coin_acceptor #(
    parameter int DEB_CYC = 4,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_raw,
    input  logic       en,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       reject,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE, GAP} state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t     state, state_n;
    logic [2:0] s1, sync;
    logic [2:0] cap, cap_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] d_n;
    logic       rej_n;
    logic       onehot;

    assign onehot = (cap == 3'b001) || (cap == 3'b010) || (cap == 3'b100);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1           <= '0;
            sync         <= '0;
            state        <= IDLE;
            cap          <= '0;
            cnt          <= '0;
            {d3, d2, d1} <= '0;
            reject       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s1           <= coin_raw;
            sync         <= s1;
            state        <= state_n;
            cap          <= cap_n;
            cnt          <= cnt_n;
            {d3, d2, d1} <= d_n;
            reject       <= rej_n;
            busy         <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        cap_n   = cap;
        cnt_n   = cnt;
        d_n     = '0;
        rej_n   = 1'b0;
        case (state)
            IDLE: begin
                if (sync != 3'b000) begin
                    cap_n   = sync;
                    cnt_n   = 4'd1;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync == cap) begin
                    if (cnt == DEB_LAST) begin
                        // en only matters at this single decision edge
                        if (onehot && en) d_n = cap;
                        else              rej_n = 1'b1;
                        cnt_n   = 4'd0;
                        state_n = RELEASE;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end else if (sync == 3'b000) begin
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cap_n = sync;
                    cnt_n = 4'd1;
                end
            end
            RELEASE: begin
                if (sync != 3'b000) begin
                    cnt_n = 4'd0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = 4'd0;
                    state_n = (GAP_CYC == 0) ? IDLE : GAP;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: each scenario drives raw slot patterns and
// checks pulse counts and edge timing against hand-derived values.
module tb_coin_acceptor;

    localparam int DEB_CYC = 4;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] coin_raw;
    logic       en;
    logic       d1, d2, d3, reject, busy;

    int checks = 0;
    int errors = 0;

    // per-run tallies: pulse counts, edge index of last pulse, busy span
    int n1, n2, n3, nr, e1, e2, e3, er, nbusy, bf, bl, ovl;

    coin_acceptor #(.DEB_CYC(DEB_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .coin_raw(coin_raw), .en(en),
        .d1(d1), .d2(d2), .d3(d3), .reject(reject), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; step returns at the next negedge so outputs
    // reflect the posedge just taken.
    task automatic step(input logic [2:0] raw);
        coin_raw = raw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_tally();
        n1 = 0; n2 = 0; n3 = 0; nr = 0;
        e1 = -1; e2 = -1; e3 = -1; er = -1;
        nbusy = 0; bf = -1; bl = -1; ovl = 0;
    endtask

    task automatic tally(input int k);
        if (d1)     begin n1++; e1 = k; end
        if (d2)     begin n2++; e2 = k; end
        if (d3)     begin n3++; e3 = k; end
        if (reject) begin nr++; er = k; end
        if (busy) begin
            if (nbusy == 0) bf = k;
            nbusy++;
            bl = k;
        end
        if ($countones({d1, d2, d3, reject}) > 1) ovl++;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 25; i++) step(3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; coin_raw = 3'b000;
        repeat (3) @(negedge clk);
        checks++;
        if ({d1, d2, d3, reject, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {d1, d2, d3, reject, busy});
        end
        rst = 1'b1;
        go_idle();
    endtask

    task automatic test_clean();
        clear_tally();
        for (int k = 0; k < 30; k++) begin
            step(k < 12 ? 3'b010 : 3'b000);
            tally(k);
        end
        checks++;
        if (n2 !== 1 || e2 !== 5) begin
            errors++;
            $display("FAIL clean_d2: got count %0d edge %0d expected 1 at edge 5", n2, e2);
        end
        checks++;
        if (n1 + n3 + nr !== 0) begin
            errors++;
            $display("FAIL clean_others: got %0d other pulses expected 0", n1 + n3 + nr);
        end
        checks++;
        if (bf !== 2 || bl !== 18 || nbusy !== 17) begin
            errors++;
            $display("FAIL clean_busy: got first %0d last %0d count %0d expected 2 18 17", bf, bl, nbusy);
        end
        go_idle();
    endtask

    task automatic test_glitch();
        clear_tally();
        for (int k = 0; k < 20; k++) begin
            step(k < 2 ? 3'b001 : 3'b000);
            tally(k);
        end
        checks++;
        if (n1 + nr !== 0) begin
            errors++;
            $display("FAIL glitch_pulse: got d1 %0d reject %0d expected 0 0", n1, nr);
        end
        checks++;
        if (nbusy !== 2 || bf !== 2 || bl !== 3) begin
            errors++;
            $display("FAIL glitch_busy: got count %0d first %0d last %0d expected 2 2 3", nbusy, bf, bl);
        end
        go_idle();
    endtask

    task automatic test_bounce();
        logic [7:0] pb;
        pb = 8'b1111_1101;
        clear_tally();
        for (int k = 0; k < 25; k++) begin
            step((k < 8 && pb[k]) ? 3'b100 : 3'b000);
            tally(k);
        end
        checks++;
        if (n3 !== 1 || e3 !== 7) begin
            errors++;
            $display("FAIL bounce_d3: got count %0d edge %0d expected 1 at edge 7", n3, e3);
        end
        checks++;
        if (n1 + n2 + nr !== 0) begin
            errors++;
            $display("FAIL bounce_others: got %0d expected 0", n1 + n2 + nr);
        end
        go_idle();
    endtask

    task automatic test_illegal();
        clear_tally();
        for (int k = 0; k < 25; k++) begin
            step(k < 10 ? 3'b101 : 3'b000);
            tally(k);
        end
        checks++;
        if (nr !== 1 || er !== 5) begin
            errors++;
            $display("FAIL illegal_reject: got count %0d edge %0d expected 1 at edge 5", nr, er);
        end
        checks++;
        if (n1 + n2 + n3 !== 0) begin
            errors++;
            $display("FAIL illegal_coin: got %0d coin pulses expected 0", n1 + n2 + n3);
        end
        go_idle();
    endtask

    task automatic test_disabled();
        en = 1'b0;
        clear_tally();
        for (int k = 0; k < 25; k++) begin
            step(k < 10 ? 3'b100 : 3'b000);
            tally(k);
        end
        en = 1'b1;
        checks++;
        if (nr !== 1 || er !== 5) begin
            errors++;
            $display("FAIL disabled_reject: got count %0d edge %0d expected 1 at edge 5", nr, er);
        end
        checks++;
        if (n3 !== 0) begin
            errors++;
            $display("FAIL disabled_d3: got %0d expected 0", n3);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        clear_tally();
        for (int k = 0; k < 35; k++) begin
            step(k < 4 ? 3'b001 : (k >= 10 && k < 14) ? 3'b010 : 3'b000);
            tally(k);
        end
        checks++;
        if (n1 !== 1 || e1 !== 5 || n2 !== 1 || e2 !== 15) begin
            errors++;
            $display("FAIL b2b_timing: got d1 %0d@%0d d2 %0d@%0d expected 1@5 1@15", n1, e1, n2, e2);
        end
        checks++;
        if (e2 - e1 < 2 * DEB_CYC + GAP_CYC || ovl !== 0) begin
            errors++;
            $display("FAIL b2b_spacing: got gap %0d overlaps %0d expected >=%0d and 0",
                     e2 - e1, ovl, 2 * DEB_CYC + GAP_CYC);
        end
        go_idle();
        // a coin held through RELEASE must not be counted twice
        clear_tally();
        for (int k = 0; k < 30; k++) begin
            step(k < 15 ? 3'b001 : 3'b000);
            tally(k);
        end
        checks++;
        if (n1 !== 1 || e1 !== 5) begin
            errors++;
            $display("FAIL hold_single: got count %0d edge %0d expected 1 at edge 5", n1, e1);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) step(3'b001);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({d1, d2, d3, reject, busy} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b expected 00000", {d1, d2, d3, reject, busy});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_tally();
        for (int k = 0; k < 12; k++) begin
            step(3'b001);
            tally(k);
        end
        checks++;
        if (n1 !== 1 || e1 !== DEB_CYC + 1) begin
            errors++;
            $display("FAIL mid_reset_d1: got count %0d edge %0d expected 1 at edge %0d", n1, e1, DEB_CYC + 1);
        end
        go_idle();
    endtask

    initial begin
        coin_raw = 3'b000;
        en = 1'b1;
        rst = 1'b0;
        test_reset();
        test_clean();
        test_glitch();
        test_bounce();
        test_illegal();
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
